// File: rtl/bht_ctrl.sv
// Branch history table controller: clears a 2-bit counter RAM after reset, serves
// single-cycle lookups on port 1 and applies queued saturating updates on port 2.
module bht_ctrl #(
    parameter int         LOGINDEX  = 8,
    parameter int         INDEXSIZE = 256,
    parameter logic [1:0] INITVALUE = 2'd1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                lk_valid_in,
    input  logic [LOGINDEX-1:0] lk_index_in,
    output logic                lk_ready_out,
    output logic                lk_valid_out,
    output logic                lk_taken_out,
    input  logic                up_valid_in,
    input  logic [LOGINDEX-1:0] up_index_in,
    input  logic                up_taken_in,
    output logic                up_ready_out,
    output logic                init_done_out,
    output logic                ram_we1_out,
    output logic [LOGINDEX-1:0] ram_index1_out,
    output logic [1:0]          ram_data1_out,
    input  logic [1:0]          ram_data1_in,
    output logic                ram_we2_out,
    output logic [LOGINDEX-1:0] ram_index2_out,
    output logic [1:0]          ram_data2_out,
    input  logic [1:0]          ram_data2_in
);

    localparam logic [LOGINDEX-1:0] LAST_IDX = LOGINDEX'(INDEXSIZE - 1);

    typedef enum logic [1:0] {CLEAR, IDLE, UPD_RD, UPD_WR} state_t;

    state_t              state, state_nxt;
    logic [LOGINDEX-1:0] sweep_cnt;
    logic                init_done;

    logic [LOGINDEX:0]   fifo_mem [4];
    logic [1:0]          wr_ptr, rd_ptr;
    logic [2:0]          count;
    logic                push, pop;
    logic [LOGINDEX:0]   head;

    logic [LOGINDEX-1:0] upd_idx_p1;
    logic                upd_taken_p1;
    logic [1:0]          upd_ctr_p1;
    logic [1:0]          upd_new;

    logic                lk_acc, lk_bypass, lk_taken_p0;
    logic                lk_vld_p1, lk_taken_p1;

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'd3) ? 2'd3 : ctr + 2'd1;
        else
            return (ctr == 2'd0) ? 2'd0 : ctr - 2'd1;
    endfunction

    assign push = up_valid_in & up_ready_out;
    assign pop  = (state == UPD_RD);
    assign head = fifo_mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (sweep_cnt == LAST_IDX) state_nxt = IDLE;
            IDLE:    if (count != 3'd0) state_nxt = UPD_RD;
            UPD_RD:  state_nxt = UPD_WR;
            UPD_WR:  state_nxt = (count != 3'd0) ? UPD_RD : IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= CLEAR;
            sweep_cnt <= '0;
            init_done <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            lk_vld_p1 <= 1'b0;
        end else begin
            state     <= state_nxt;
            lk_vld_p1 <= lk_acc;
            if (state == CLEAR) begin
                sweep_cnt <= sweep_cnt + 1'b1;
                if (sweep_cnt == LAST_IDX) init_done <= 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            if (push && !pop)      count <= count + 3'd1;
            else if (pop && !push) count <= count - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {up_index_in, up_taken_in};
    end

    // p0 -> p1: update read stage captures the RAM counter and the popped entry
    always_ff @(posedge clk) begin
        if (state == UPD_RD) begin
            upd_ctr_p1   <= ram_data2_in;
            upd_idx_p1   <= head[LOGINDEX:1];
            upd_taken_p1 <= head[0];
        end
    end

    assign upd_new = sat_update(upd_ctr_p1, upd_taken_p1);

    // A lookup colliding with the in-flight write must see the new counter.
    assign lk_acc      = lk_valid_in & lk_ready_out;
    assign lk_bypass   = (state == UPD_WR) && (upd_idx_p1 == lk_index_in);
    assign lk_taken_p0 = lk_bypass ? upd_new[1] : ram_data1_in[1];

    // p0 -> p1: lookup result stage
    always_ff @(posedge clk) begin
        lk_taken_p1 <= lk_taken_p0;
    end

    assign lk_ready_out   = (state != CLEAR);
    assign lk_valid_out   = lk_vld_p1;
    assign lk_taken_out   = lk_vld_p1 & lk_taken_p1;
    assign up_ready_out   = (count != 3'd4) && (state != CLEAR);
    assign init_done_out  = init_done;

    assign ram_we1_out    = (state == CLEAR);
    assign ram_index1_out = (state == CLEAR) ? sweep_cnt : lk_index_in;
    assign ram_data1_out  = INITVALUE;

    assign ram_we2_out    = (state == UPD_WR);
    assign ram_index2_out = (state == UPD_WR) ? upd_idx_p1 : head[LOGINDEX:1];
    assign ram_data2_out  = upd_new;

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed bench for bht_ctrl with a behavioural dual-port counter RAM.
module tb_bht_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       lk_valid_in, lk_ready_out, lk_valid_out, lk_taken_out;
    logic [7:0] lk_index_in;
    logic       up_valid_in, up_taken_in, up_ready_out, init_done_out;
    logic [7:0] up_index_in;
    logic       ram_we1_out, ram_we2_out;
    logic [7:0] ram_index1_out, ram_index2_out;
    logic [1:0] ram_data1_out, ram_data1_in, ram_data2_out, ram_data2_in;

    logic [1:0] ram [256];
    int vectors = 0;
    int miscompares = 0;
    int p2_writes = 0;
    int collisions = 0;

    bht_ctrl #(.LOGINDEX(8), .INDEXSIZE(256), .INITVALUE(2'd1)) dut (
        .clk(clk), .reset(reset),
        .lk_valid_in(lk_valid_in), .lk_index_in(lk_index_in), .lk_ready_out(lk_ready_out),
        .lk_valid_out(lk_valid_out), .lk_taken_out(lk_taken_out),
        .up_valid_in(up_valid_in), .up_index_in(up_index_in), .up_taken_in(up_taken_in),
        .up_ready_out(up_ready_out), .init_done_out(init_done_out),
        .ram_we1_out(ram_we1_out), .ram_index1_out(ram_index1_out),
        .ram_data1_out(ram_data1_out), .ram_data1_in(ram_data1_in),
        .ram_we2_out(ram_we2_out), .ram_index2_out(ram_index2_out),
        .ram_data2_out(ram_data2_out), .ram_data2_in(ram_data2_in)
    );

    always #5 clk = ~clk;

    assign ram_data1_in = ram[ram_index1_out];
    assign ram_data2_in = ram[ram_index2_out];

    always @(posedge clk) begin
        if (ram_we1_out) ram[ram_index1_out] <= ram_data1_out;
        if (ram_we2_out) ram[ram_index2_out] <= ram_data2_out;
        if (ram_we2_out) p2_writes <= p2_writes + 1;
        if (ram_we1_out && ram_we2_out) collisions <= collisions + 1;
    end

    // Follows a running sweep from the current negedge; lookups and updates are offered throughout.
    task automatic run_sweep(output int n, output int bad);
        n = 0;
        bad = 0;
        lk_valid_in = 1'b1; lk_index_in = 8'd3;
        up_valid_in = 1'b1; up_index_in = 8'd60; up_taken_in = 1'b1;
        while (ram_we1_out && n < 300) begin
            if (ram_index1_out !== n[7:0] || ram_data1_out !== 2'd1 || init_done_out !== 1'b0 ||
                lk_valid_out !== 1'b0 || up_ready_out !== 1'b0 || lk_ready_out !== 1'b0)
                bad++;
            n++;
            @(negedge clk);
        end
        lk_valid_in = 1'b0;
        up_valid_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        lk_valid_in = 1'b0; lk_index_in = '0;
        up_valid_in = 1'b0; up_index_in = '0; up_taken_in = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (lk_valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_lk_valid: got %0b want 0", lk_valid_out); end
        vectors++; if (lk_taken_out !== 1'b0) begin miscompares++; $display("FAIL reset_lk_taken: got %0b want 0", lk_taken_out); end
        vectors++; if (init_done_out !== 1'b0) begin miscompares++; $display("FAIL reset_init_done: got %0b want 0", init_done_out); end
        vectors++; if (lk_ready_out !== 1'b0) begin miscompares++; $display("FAIL reset_lk_ready: got %0b want 0", lk_ready_out); end
        vectors++; if (up_ready_out !== 1'b0) begin miscompares++; $display("FAIL reset_up_ready: got %0b want 0", up_ready_out); end
        vectors++; if (ram_we2_out !== 1'b0) begin miscompares++; $display("FAIL reset_we2: got %0b want 0", ram_we2_out); end
        vectors++; if (ram_we1_out !== 1'b1) begin miscompares++; $display("FAIL reset_we1: got %0b want 1", ram_we1_out); end
        vectors++; if (ram_index1_out !== 8'd0) begin miscompares++; $display("FAIL reset_index1: got %0d want 0", ram_index1_out); end
        vectors++; if (ram_data1_out !== 2'd1) begin miscompares++; $display("FAIL reset_data1: got %0d want 1", ram_data1_out); end
    endtask

    task automatic test_clear();
        int n, bad, p2_before, not_one;
        p2_before = p2_writes;
        reset = 1'b1;
        run_sweep(n, bad);
        vectors++; if (n != 256) begin miscompares++; $display("FAIL clear_write_count: got %0d want 256", n); end
        vectors++; if (bad != 0) begin miscompares++; $display("FAIL clear_sweep_cycles: got %0d bad cycles want 0", bad); end
        vectors++; if (init_done_out !== 1'b1) begin miscompares++; $display("FAIL clear_init_done: got %0b want 1", init_done_out); end
        vectors++; if (up_ready_out !== 1'b1 || lk_ready_out !== 1'b1) begin miscompares++; $display("FAIL clear_ready: got up=%0b lk=%0b want 1/1", up_ready_out, lk_ready_out); end
        vectors++; if (ram_we1_out !== 1'b0) begin miscompares++; $display("FAIL clear_we1_after: got %0b want 0", ram_we1_out); end
        not_one = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 2'd1) not_one++;
        vectors++; if (not_one != 0) begin miscompares++; $display("FAIL clear_ram_contents: got %0d entries not 1 want 0", not_one); end
        repeat (4) @(negedge clk);
        vectors++; if (init_done_out !== 1'b1) begin miscompares++; $display("FAIL clear_init_sticky: got %0b want 1", init_done_out); end
        vectors++; if (p2_writes != p2_before) begin miscompares++; $display("FAIL clear_ignored_updates: got %0d port2 writes want 0", p2_writes - p2_before); end
    endtask

    task automatic test_lookup();
        lk_valid_in = 1'b1; lk_index_in = 8'd5;
        @(negedge clk);
        lk_valid_in = 1'b0;
        vectors++; if (lk_valid_out !== 1'b1 || lk_taken_out !== 1'b0) begin miscompares++; $display("FAIL lookup5: got valid=%0b taken=%0b want 1/0", lk_valid_out, lk_taken_out); end
        @(negedge clk);
        vectors++; if (lk_valid_out !== 1'b0) begin miscompares++; $display("FAIL lookup5_single: got valid=%0b want 0", lk_valid_out); end
    endtask

    task automatic test_update_sat();
        up_index_in = 8'd7; up_taken_in = 1'b1;
        for (int c = 0; c < 9; c++) begin
            up_valid_in = (c < 3);
            if (c < 3) begin
                vectors++; if (up_ready_out !== 1'b1) begin miscompares++; $display("FAIL upd7_ready c%0d: got %0b want 1", c, up_ready_out); end
            end
            if (c == 3 || c == 5 || c == 7) begin
                vectors++;
                if (ram_we2_out !== 1'b1 || ram_index2_out !== 8'd7 || ram_data2_out !== ((c == 3) ? 2'd2 : 2'd3)) begin
                    miscompares++;
                    $display("FAIL upd7_write c%0d: got we=%0b idx=%0d data=%0d want 1/7/%0d", c, ram_we2_out, ram_index2_out, ram_data2_out, (c == 3) ? 2 : 3);
                end
            end
            if (c == 4 || c == 6 || c == 8) begin
                vectors++; if (ram[7] !== ((c == 4) ? 2'd2 : 2'd3)) begin miscompares++; $display("FAIL upd7_ram c%0d: got %0d want %0d", c, ram[7], (c == 4) ? 2 : 3); end
            end
            @(negedge clk);
        end
        vectors++; if (ram_we2_out !== 1'b0) begin miscompares++; $display("FAIL upd7_idle_we2: got %0b want 0", ram_we2_out); end
        lk_valid_in = 1'b1; lk_index_in = 8'd7;
        @(negedge clk);
        lk_valid_in = 1'b0;
        vectors++; if (lk_valid_out !== 1'b1 || lk_taken_out !== 1'b1) begin miscompares++; $display("FAIL lookup7: got valid=%0b taken=%0b want 1/1", lk_valid_out, lk_taken_out); end
    endtask

    task automatic test_floor();
        up_index_in = 8'd50; up_taken_in = 1'b0;
        up_valid_in = 1'b1;
        repeat (2) @(negedge clk);
        up_valid_in = 1'b0;
        repeat (10) @(negedge clk);
        vectors++; if (ram[50] !== 2'd0) begin miscompares++; $display("FAIL floor50_ram: got %0d want 0", ram[50]); end
        lk_valid_in = 1'b1; lk_index_in = 8'd50;
        @(negedge clk);
        lk_valid_in = 1'b0;
        vectors++; if (lk_valid_out !== 1'b1 || lk_taken_out !== 1'b0) begin miscompares++; $display("FAIL lookup50: got valid=%0b taken=%0b want 1/0", lk_valid_out, lk_taken_out); end
    endtask

    // Pushing every cycle outruns the one-per-two-cycle drain; the request that meets a full FIFO must be held.
    task automatic test_fifo_full();
        logic [7:0] exp_ready;
        int k, p2_before;
        exp_ready = 8'b1011_1111;
        k = 0;
        p2_before = p2_writes;
        up_taken_in = 1'b1;
        for (int c = 0; c < 8; c++) begin
            up_valid_in = 1'b1;
            up_index_in = 8'(20 + k);
            vectors++; if (up_ready_out !== exp_ready[c]) begin miscompares++; $display("FAIL full_ready c%0d: got %0b want %0b", c, up_ready_out, exp_ready[c]); end
            if (exp_ready[c]) k++;
            @(negedge clk);
        end
        up_valid_in = 1'b0;
        repeat (20) @(negedge clk);
        vectors++; if (p2_writes - p2_before != 7) begin miscompares++; $display("FAIL full_write_count: got %0d want 7", p2_writes - p2_before); end
        for (int i = 20; i < 27; i++) begin
            vectors++; if (ram[i] !== 2'd2) begin miscompares++; $display("FAIL full_ram%0d: got %0d want 2", i, ram[i]); end
        end
    endtask

    task automatic test_bypass();
        up_index_in = 8'd9; up_taken_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            up_valid_in = (c == 0);
            if (c == 3) begin
                vectors++;
                if (ram_we2_out !== 1'b1 || ram_index2_out !== 8'd9 || ram_data2_out !== 2'd2) begin
                    miscompares++;
                    $display("FAIL bypass_write: got we=%0b idx=%0d data=%0d want 1/9/2", ram_we2_out, ram_index2_out, ram_data2_out);
                end
                lk_valid_in = 1'b1; lk_index_in = 8'd9;
            end
            if (c == 4) begin
                lk_valid_in = 1'b0;
                vectors++; if (lk_valid_out !== 1'b1 || lk_taken_out !== 1'b1) begin miscompares++; $display("FAIL bypass_lookup9: got valid=%0b taken=%0b want 1/1", lk_valid_out, lk_taken_out); end
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int steps, n, bad, p2_before;
        p2_before = p2_writes;
        up_taken_in = 1'b1;
        up_valid_in = 1'b1; up_index_in = 8'd40;
        @(negedge clk);
        up_index_in = 8'd41;
        @(negedge clk);
        up_valid_in = 1'b0;
        reset = 1'b0;
        #1;
        vectors++; if (ram_we2_out !== 1'b0 || up_ready_out !== 1'b0 || lk_ready_out !== 1'b0) begin miscompares++; $display("FAIL midupd_reset: got we2=%0b up=%0b lk=%0b want 0/0/0", ram_we2_out, up_ready_out, lk_ready_out); end
        @(negedge clk);
        reset = 1'b1;
        steps = 0;
        while (ram_index1_out !== 8'd100 && steps < 300) begin
            steps++;
            @(negedge clk);
        end
        vectors++; if (steps != 100) begin miscompares++; $display("FAIL midsweep_reach100: got %0d cycles want 100", steps); end
        reset = 1'b0;
        #1;
        vectors++; if (ram_index1_out !== 8'd0 || ram_we1_out !== 1'b1) begin miscompares++; $display("FAIL midsweep_async: got idx=%0d we1=%0b want 0/1", ram_index1_out, ram_we1_out); end
        @(negedge clk);
        reset = 1'b1;
        run_sweep(n, bad);
        vectors++; if (n != 256 || bad != 0) begin miscompares++; $display("FAIL resweep: got %0d writes %0d bad want 256/0", n, bad); end
        vectors++; if (init_done_out !== 1'b1) begin miscompares++; $display("FAIL resweep_init_done: got %0b want 1", init_done_out); end
        repeat (10) @(negedge clk);
        vectors++; if (p2_writes != p2_before) begin miscompares++; $display("FAIL discard_pending: got %0d port2 writes want 0", p2_writes - p2_before); end
        vectors++; if (ram[40] !== 2'd1 || ram[41] !== 2'd1) begin miscompares++; $display("FAIL discard_ram: got %0d/%0d want 1/1", ram[40], ram[41]); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_lookup();
        test_update_sat();
        test_floor();
        test_fifo_full();
        test_bypass();
        test_reset_mid();
        vectors++; if (collisions != 0) begin miscompares++; $display("FAIL port_collision: got %0d cycles want 0", collisions); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
